// File: rtl/interleave_ctrl_sequencer_if.sv
// Control/handshake bundle between the host-side ap_ctrl signals and the channel sequencer.
// The slave side is the sequencer; the master side is whatever drives ap_start and the channel dones.
interface interleave_ctrl_sequencer_if #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_STAGGER_WIDTH   = 8,
    parameter int C_CYCLE_CNT_WIDTH = 32
);
    logic                         ap_start;
    logic                         ap_continue;
    logic                         ap_idle;
    logic                         ap_ready;
    logic                         ap_done;
    logic [C_NUM_CHANNELS-1:0]    ctrl_chan_en;
    logic [C_STAGGER_WIDTH-1:0]   ctrl_stagger;
    logic [C_NUM_CHANNELS-1:0]    ch_start;
    logic [C_NUM_CHANNELS-1:0]    ch_done;
    logic [C_NUM_CHANNELS-1:0]    ch_done_vec;
    logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count;

    modport slave (
        input  ap_start, ap_continue, ctrl_chan_en, ctrl_stagger, ch_done,
        output ap_idle, ap_ready, ap_done, ch_start, ch_done_vec, cycle_count
    );

    modport master (
        output ap_start, ap_continue, ctrl_chan_en, ctrl_stagger, ch_done,
        input  ap_idle, ap_ready, ap_done, ch_start, ch_done_vec, cycle_count
    );
endinterface

// File: rtl/interleave_ctrl_sequencer.sv
// N-channel ap_ctrl sequencer: launches enabled channels in index order with a fixed stagger,
// collects per-channel completion and reports ap_ready/ap_done/ap_idle plus run length.
module interleave_ctrl_sequencer #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_STAGGER_WIDTH   = 8,
    parameter int C_CHAIN_MODE      = 0,
    parameter int C_CYCLE_CNT_WIDTH = 32
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    interleave_ctrl_sequencer_if.slave ctrl
);
    localparam int N  = C_NUM_CHANNELS;
    localparam int SW = C_STAGGER_WIDTH;
    localparam int CW = C_CYCLE_CNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    en_mask;
    logic [N-1:0]    started;
    logic [N-1:0]    pending;
    logic [SW-1:0]   stagger;
    logic [SW-1:0]   gap_cnt;
    logic [N-1:0]    ch_start_q;
    logic [N-1:0]    ch_done_vec_q;
    logic [CW-1:0]   cycle_count_q;
    logic            ap_idle_q;
    logic            ap_ready_q;
    logic            ap_done_q;

    logic [N-1:0]    done_hit;
    logic [N-1:0]    done_all;
    logic [N-1:0]    accept_first;
    logic [N-1:0]    accept_rest;
    logic [N-1:0]    next_pick;
    logic [N-1:0]    pending_rest;
    logic [CW-1:0]   cnt_next;

    // Isolates the lowest set bit, i.e. the next channel in ascending index order.
    function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
        return v & (~v + N'(1));
    endfunction

    always_comb begin
        // NOTE: every signal gets a value on every path here, so no latch can be inferred.
        done_hit     = ctrl.ch_done & started & en_mask;
        done_all     = ch_done_vec_q | done_hit;
        accept_first = lowest_bit(ctrl.ctrl_chan_en);
        accept_rest  = ctrl.ctrl_chan_en & ~accept_first;
        next_pick    = lowest_bit(pending);
        pending_rest = pending & ~next_pick;
        cnt_next     = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CW'(1);
    end

    // NOTE: all state, including the latched configuration, is reset so a mid-run reset leaves nothing stale.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= S_IDLE;
            en_mask       <= '0;
            started       <= '0;
            pending       <= '0;
            stagger       <= '0;
            gap_cnt       <= '0;
            ch_start_q    <= '0;
            ch_done_vec_q <= '0;
            cycle_count_q <= '0;
            ap_idle_q     <= 1'b1;
            ap_ready_q    <= 1'b0;
            ap_done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make ch_start and ap_ready single-cycle pulses unless overridden below.
            ch_start_q <= '0;
            ap_ready_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ctrl.ap_start) begin
                        en_mask       <= ctrl.ctrl_chan_en;
                        stagger       <= ctrl.ctrl_stagger;
                        gap_cnt       <= ctrl.ctrl_stagger;
                        ch_start_q    <= accept_first;
                        started       <= accept_first;
                        pending       <= accept_rest;
                        ap_ready_q    <= (accept_rest == '0);
                        ch_done_vec_q <= '0;
                        cycle_count_q <= '0;
                        ap_idle_q     <= 1'b0;
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    ch_done_vec_q <= done_all;
                    cycle_count_q <= cnt_next;
                    // An empty pending set means ap_ready is already showing for the last launch.
                    if (pending == '0) begin
                        state <= S_WAIT;
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - SW'(1);
                    end else begin
                        ch_start_q <= next_pick;
                        started    <= started | next_pick;
                        pending    <= pending_rest;
                        ap_ready_q <= (pending_rest == '0);
                        gap_cnt    <= stagger;
                    end
                end
                S_WAIT: begin
                    ch_done_vec_q <= done_all;
                    cycle_count_q <= cnt_next;
                    if (done_all == en_mask) begin
                        ap_done_q <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (C_CHAIN_MODE == 0 || ctrl.ap_continue) begin
                        ap_done_q <= 1'b0;
                        ap_idle_q <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl.ap_idle     = ap_idle_q;
    assign ctrl.ap_ready    = ap_ready_q;
    assign ctrl.ap_done     = ap_done_q;
    assign ctrl.ch_start    = ch_start_q;
    assign ctrl.ch_done_vec = ch_done_vec_q;
    assign ctrl.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_interleave_ctrl_sequencer.sv
// Bench for interleave_ctrl_sequencer: hand-derived vector table, reset/chain sequences,
// and random runs scored against a timeline model built from the launch/complete rules.
module tb_interleave_ctrl_sequencer;
    localparam int NO = 4095;

    typedef logic [3:0][11:0] sched_t;
    typedef struct {
        logic [3:0] en;
        logic [7:0] stagger;
        sched_t     done_at;
        sched_t     stray_at;
        sched_t     exp_start;
        int         exp_ready;
        int         exp_done;
        int         exp_count;
        logic [3:0] exp_vec;
    } vec_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    interleave_ctrl_sequencer_if #(.C_NUM_CHANNELS(4), .C_STAGGER_WIDTH(8), .C_CYCLE_CNT_WIDTH(32)) hs ();
    interleave_ctrl_sequencer_if #(.C_NUM_CHANNELS(4), .C_STAGGER_WIDTH(8), .C_CYCLE_CNT_WIDTH(32)) cif ();

    interleave_ctrl_sequencer #(
        .C_NUM_CHANNELS(4), .C_STAGGER_WIDTH(8), .C_CHAIN_MODE(0), .C_CYCLE_CNT_WIDTH(32)
    ) dut_hs (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ctrl    (hs.slave)
    );

    interleave_ctrl_sequencer #(
        .C_NUM_CHANNELS(4), .C_STAGGER_WIDTH(8), .C_CHAIN_MODE(1), .C_CYCLE_CNT_WIDTH(32)
    ) dut_chain (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ctrl    (cif.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic sched_t sch(input int a0, input int a1, input int a2, input int a3);
        sched_t s;
        s[0] = 12'(a0);
        s[1] = 12'(a1);
        s[2] = 12'(a2);
        s[3] = 12'(a3);
        return s;
    endfunction

    function automatic vec_t mk(input logic [3:0] en, input int st, input sched_t dn, input sched_t sy,
                                input sched_t es, input int rdy, input int dne, input int cnt,
                                input logic [3:0] vec);
        vec_t v;
        v.en = en; v.stagger = 8'(st); v.done_at = dn; v.stray_at = sy;
        v.exp_start = es; v.exp_ready = rdy; v.exp_done = dne; v.exp_count = cnt; v.exp_vec = vec;
        return v;
    endfunction

    // Launch timeline: enabled channels in ascending order, first at cycle 1, then every stagger+1.
    function automatic sched_t start_times(input logic [3:0] en, input logic [7:0] stagger);
        sched_t s;
        int t = 1;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                s[i] = 12'(t);
                t += int'(stagger) + 1;
            end else begin
                s[i] = 12'(NO);
            end
        end
        return s;
    endfunction

    // A channel completes at its earliest done pulse not before its own launch; the run finishes at
    // the later of the first wait cycle and the last completion, with ap_done visible one cycle on.
    function automatic vec_t model(input vec_t v);
        int fin;
        int c;
        v.exp_start = start_times(v.en, v.stagger);
        v.exp_ready = 1;
        for (int i = 0; i < 4; i++) if (v.en[i]) v.exp_ready = int'(v.exp_start[i]);
        fin = v.exp_ready + 1;
        v.exp_vec = '0;
        for (int i = 0; i < 4; i++) begin
            if (v.en[i]) begin
                c = NO;
                if (v.done_at[i] != 12'(NO) && v.done_at[i] >= v.exp_start[i]) c = int'(v.done_at[i]);
                if (v.stray_at[i] != 12'(NO) && v.stray_at[i] >= v.exp_start[i] && int'(v.stray_at[i]) < c)
                    c = int'(v.stray_at[i]);
                if (c != NO) begin
                    v.exp_vec[i] = 1'b1;
                    if (c > fin) fin = c;
                end
            end
        end
        v.exp_count = fin;
        v.exp_done  = fin + 1;
        return v;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge ap_clk);
        while (!hs.ap_idle && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check({name, " idle_before_start"}, hs.ap_idle, 1);
    endtask

    // Runs one accept-to-idle transaction on the hs instance; cycle k is sampled at its negedge.
    task automatic run_case(input int id, input vec_t v);
        string nm;
        int    start_at[4];
        int    start_cnt;
        int    ready_at;
        int    ready_cnt;
        int    done_c;
        int    idle_hi;
        longint cnt_at_done;
        logic [3:0] vec_at_done;
        nm = $sformatf("case%0d", id);
        wait_idle(nm);
        hs.ap_start = 1'b1;
        hs.ctrl_chan_en = v.en;
        hs.ctrl_stagger = v.stagger;
        for (int i = 0; i < 4; i++) start_at[i] = NO;
        start_cnt = 0; ready_at = -1; ready_cnt = 0; done_c = -1; idle_hi = 0;
        cnt_at_done = -1; vec_at_done = 'x;
        @(posedge ap_clk);
        for (int k = 1; k <= 1000 && done_c < 0; k++) begin
            @(negedge ap_clk);
            hs.ap_start = 1'b0;
            hs.ctrl_chan_en = 4'($urandom);
            hs.ctrl_stagger = 8'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (hs.ch_start[i]) begin
                    if (start_at[i] == NO) start_at[i] = k;
                    start_cnt++;
                end
            end
            if (hs.ap_ready) begin
                if (ready_at < 0) ready_at = k;
                ready_cnt++;
            end
            if (hs.ap_idle) idle_hi++;
            if (hs.ap_done) begin
                done_c = k;
                cnt_at_done = hs.cycle_count;
                vec_at_done = hs.ch_done_vec;
            end
            for (int i = 0; i < 4; i++)
                hs.ch_done[i] = (v.done_at[i] == 12'(k)) || (v.stray_at[i] == 12'(k));
        end
        hs.ch_done = '0;
        for (int i = 0; i < 4; i++) check($sformatf("%s start_cycle[%0d]", nm, i), start_at[i], v.exp_start[i]);
        check({nm, " start_pulses"}, start_cnt, $countones(v.en));
        check({nm, " ready_cycle"}, ready_at, v.exp_ready);
        check({nm, " ready_pulses"}, ready_cnt, 1);
        check({nm, " done_cycle"}, done_c, v.exp_done);
        check({nm, " cycle_count"}, cnt_at_done, v.exp_count);
        check({nm, " ch_done_vec"}, vec_at_done, v.exp_vec);
        check({nm, " idle_during_run"}, idle_hi, 0);
        @(negedge ap_clk);
        check({nm, " done_dropped"}, hs.ap_done, 0);
        check({nm, " idle_after"}, hs.ap_idle, 1);
        check({nm, " vec_held"}, hs.ch_done_vec, v.exp_vec);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;
        sched_t st;
        int ored;
        int hi;
        int bad;

        ap_rst_n = 1'b0;
        hs.ap_start = 0; hs.ap_continue = 0; hs.ctrl_chan_en = 0; hs.ctrl_stagger = 0; hs.ch_done = 0;
        cif.ap_start = 0; cif.ap_continue = 0; cif.ctrl_chan_en = 0; cif.ctrl_stagger = 0; cif.ch_done = 0;
        repeat (2) @(negedge ap_clk);
        check("reset ap_idle", hs.ap_idle, 1);
        check("reset ap_ready", hs.ap_ready, 0);
        check("reset ap_done", hs.ap_done, 0);
        check("reset ch_start", hs.ch_start, 0);
        check("reset ch_done_vec", hs.ch_done_vec, 0);
        check("reset cycle_count", hs.cycle_count, 0);
        check("reset chain ap_idle", cif.ap_idle, 1);
        check("reset chain ap_done", cif.ap_done, 0);
        ap_rst_n = 1'b1;

        tbl[0] = mk(4'hF, 2, sch(20, 21, 22, 23), sch(NO, NO, NO, NO), sch(1, 4, 7, 10), 10, 24, 23, 4'hF);
        tbl[1] = mk(4'h5, 0, sch(5, NO, 6, NO), sch(NO, 3, NO, NO), sch(1, NO, 2, NO), 2, 7, 6, 4'h5);
        tbl[2] = mk(4'h0, 5, sch(NO, NO, NO, NO), sch(NO, NO, NO, NO), sch(NO, NO, NO, NO), 1, 3, 2, 4'h0);
        tbl[3] = mk(4'hF, 2, sch(3, 4, 15, 18), sch(NO, NO, NO, NO), sch(1, 4, 7, 10), 10, 19, 18, 4'hF);
        tbl[4] = mk(4'hC, 1, sch(NO, NO, 2, 5), sch(NO, NO, NO, 2), sch(NO, NO, 1, 3), 3, 6, 5, 4'hC);
        tbl[5] = mk(4'hF, 0, sch(1, 2, 3, 4), sch(NO, NO, NO, NO), sch(1, 2, 3, 4), 4, 6, 5, 4'hF);
        tbl[6] = mk(4'h3, 255, sch(2, 257, NO, NO), sch(NO, NO, NO, NO), sch(1, 257, NO, NO), 257, 259, 258, 4'h3);
        tbl[7] = mk(4'h8, 7, sch(NO, NO, NO, 9), sch(4, NO, NO, NO), sch(NO, NO, NO, 1), 1, 10, 9, 4'h8);
        for (int t = 0; t < 8; t++) run_case(t, tbl[t]);

        // Reset in the middle of LAUNCH, then a clean repeat of the first table run.
        wait_idle("midrst");
        hs.ap_start = 1'b1; hs.ctrl_chan_en = 4'hF; hs.ctrl_stagger = 8'd2;
        @(posedge ap_clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge ap_clk);
            hs.ap_start = 1'b0;
            if (k == 4) check("midrst ch_start_cycle4", hs.ch_start, 4'b0010);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        check("midrst ch_start", hs.ch_start, 0);
        check("midrst ap_idle", hs.ap_idle, 1);
        check("midrst cycle_count", hs.cycle_count, 0);
        check("midrst ch_done_vec", hs.ch_done_vec, 0);
        ored = 0;
        repeat (3) begin
            @(negedge ap_clk);
            ored |= int'(hs.ch_start);
        end
        check("midrst no_starts_in_reset", ored, 0);
        ap_rst_n = 1'b1;
        run_case(50, tbl[0]);

        // Chain mode: ap_done held until ap_continue, no re-accept while DONE.
        @(negedge ap_clk);
        cif.ap_start = 1'b1; cif.ctrl_chan_en = 4'b0001; cif.ctrl_stagger = 8'd0; cif.ap_continue = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("chain start_c1", cif.ch_start, 4'b0001);
        check("chain ready_c1", cif.ap_ready, 1);
        cif.ch_done = 4'b0001;
        @(negedge ap_clk);
        check("chain done_c2", cif.ap_done, 0);
        cif.ch_done = 4'b0000;
        hi = 0; bad = 0;
        for (int k = 3; k <= 12; k++) begin
            @(negedge ap_clk);
            if (cif.ap_done) hi++;
            if (cif.ap_idle || cif.ch_start != 4'b0000) bad++;
            if (k == 12) begin
                check("chain count_frozen", cif.cycle_count, 2);
                cif.ap_continue = 1'b1;
            end
        end
        check("chain done_held_cycles", hi, 10);
        check("chain no_reaccept", bad, 0);
        @(negedge ap_clk);
        check("chain done_c13", cif.ap_done, 0);
        check("chain idle_c13", cif.ap_idle, 1);
        @(negedge ap_clk);
        check("chain reaccept_idle_c14", cif.ap_idle, 0);
        check("chain reaccept_start_c14", cif.ch_start, 4'b0001);
        cif.ap_start = 1'b0;
        cif.ch_done = 4'b0001;
        @(negedge ap_clk);
        cif.ch_done = 4'b0000;
        check("chain done_c15", cif.ap_done, 0);
        @(negedge ap_clk);
        check("chain done_c16", cif.ap_done, 1);
        check("chain count_c16", cif.cycle_count, 2);
        check("chain vec_c16", cif.ch_done_vec, 4'b0001);
        @(negedge ap_clk);
        check("chain done_c17", cif.ap_done, 0);
        check("chain idle_c17", cif.ap_idle, 1);

        // Random runs against the timeline model.
        for (int r = 0; r < 25; r++) begin
            rv.en = 4'($urandom);
            rv.stagger = 8'($urandom_range(0, 4));
            rv.done_at = sch(NO, NO, NO, NO);
            rv.stray_at = sch(NO, NO, NO, NO);
            st = start_times(rv.en, rv.stagger);
            for (int i = 0; i < 4; i++) begin
                if (rv.en[i]) begin
                    rv.done_at[i] = 12'(int'(st[i]) + int'($urandom_range(0, 12)));
                    if (st[i] > 12'd1 && $urandom_range(0, 1) == 1)
                        rv.stray_at[i] = 12'($urandom_range(1, int'(st[i]) - 1));
                end else if ($urandom_range(0, 1) == 1) begin
                    rv.stray_at[i] = 12'($urandom_range(1, 8));
                end
            end
            rv = model(rv);
            run_case(100 + r, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
